// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg: shared state encoding, pixel width and frame sizing helper
// for the pixel stream reader.
package pix_stream_pkg;

   localparam int PIX_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_R  = 3'd1,
      RD_G  = 3'd2,
      RD_B  = 3'd3,
      CAP_B = 3'd4,
      OUT   = 3'd5
   } pix_state_e;

   // Bytes in one interleaved RGB frame; 2**ADDR_W must be at least this.
   function automatic int frame_bytes(input int w, input int h);
      return w * h * 3;
   endfunction

endpackage

// File: rtl/pix_xy_counter.sv
// pix_xy_counter: raster position counter for the pixel stream reader.
// Produces unqualified start-of-line / end-of-line / end-of-frame decodes;
// the caller gates them with its valid.
module pix_xy_counter #(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 512
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic adv,
   output logic sol,
   output logic eol,
   output logic eof
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic [XW-1:0] x;
   logic [YW-1:0] y;

   assign sol = (x == '0);
   assign eol = (x == XW'(WIDTH - 1));
   assign eof = eol && (y == YW'(HEIGHT - 1));

   // x runs across the line, wrapping into y; y saturates at the last line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (adv) begin
         if (eol) begin
            x <= '0;
            if (y != YW'(HEIGHT - 1)) y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: reads interleaved R,G,B bytes from a byte-wide
// synchronous memory (1-cycle read latency) and presents one RGB pixel per
// valid/ready handshake with sol/eol/eof flags.
// Optional: define PIX_STREAM_CKSUM_EN to add a 16-bit running checksum port.
module pixel_stream_reader
   import pix_stream_pkg::*;
#(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 512,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [PIX_W-1:0]  pix_r,
   output logic [PIX_W-1:0]  pix_g,
   output logic [PIX_W-1:0]  pix_b,
   output logic              pix_sol,
   output logic              pix_eol,
   output logic              pix_eof
`ifdef PIX_STREAM_CKSUM_EN
  ,output logic [15:0]       cksum
`endif
);

   pix_state_e        state_q;
   logic [ADDR_W-1:0] base_q;
   logic              start_ok;
   logic              hs;
   logic              sol_raw, eol_raw, eof_raw;

   // done is part of busy so a start landing on the done cycle is dropped
   assign busy      = (state_q != IDLE) || done;
   assign start_ok  = start && !busy;
   assign pix_valid = (state_q == OUT);
   assign hs        = pix_valid && pix_ready;
   assign mem_rd    = (state_q == RD_R) || (state_q == RD_G) || (state_q == RD_B);
   assign pix_sol   = pix_valid && sol_raw;
   assign pix_eol   = pix_valid && eol_raw;
   assign pix_eof   = pix_valid && eof_raw;

   pix_xy_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_xy (
      .clk   (clk),
      .rst_n (rst),
      .clr   (start_ok),
      .adv   (hs),
      .sol   (sol_raw),
      .eol   (eol_raw),
      .eof   (eof_raw)
   );

   // Read sequencer: address is registered so it holds between bursts;
   // each byte is captured the cycle after its read strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         base_q   <= '0;
         mem_addr <= '0;
         pix_r    <= '0;
         pix_g    <= '0;
         pix_b    <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  base_q   <= '0;
                  mem_addr <= '0;
                  state_q  <= RD_R;
               end
            end
            RD_R: begin
               mem_addr <= base_q + ADDR_W'(1);
               state_q  <= RD_G;
            end
            RD_G: begin
               pix_r    <= mem_rdata;
               mem_addr <= base_q + ADDR_W'(2);
               state_q  <= RD_B;
            end
            RD_B: begin
               pix_g   <= mem_rdata;
               state_q <= CAP_B;
            end
            CAP_B: begin
               pix_b   <= mem_rdata;
               state_q <= OUT;
            end
            OUT: begin
               if (pix_ready) begin
                  if (eof_raw) begin
                     done    <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     base_q   <= base_q + ADDR_W'(3);
                     mem_addr <= base_q + ADDR_W'(3);
                     state_q  <= RD_R;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PIX_STREAM_CKSUM_EN
   // Running sum of every handshaken pixel, restarted by an accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          cksum <= '0;
      else if (start_ok) cksum <= '0;
      else if (hs)       cksum <= cksum + 16'(pix_r) + 16'(pix_g) + 16'(pix_b);
   end
`endif

endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb_pixel_stream_reader: directed bench. Main DUT is 4x2, a second DUT is
// 1x1; both read a memory model returning byte[i] = i.
module tb_pixel_stream_reader;

   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          rst, start, pix_ready, start1, pix_ready1;
   logic          busy, done, mem_rd, pix_valid, pix_sol, pix_eol, pix_eof;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata, pix_r, pix_g, pix_b;
   logic          busy1, done1, mem_rd1, pix_valid1, pix_sol1, pix_eol1, pix_eof1;
   logic [AW-1:0] mem_addr1;
   logic [7:0]    mem_rdata1, pix_r1, pix_g1, pix_b1;
`ifdef PIX_STREAM_CKSUM_EN
   logic [15:0]   cksum, cksum1;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd)  mem_rdata  <= mem_addr[7:0];
   always @(posedge clk) if (mem_rd1) mem_rdata1 <= mem_addr1[7:0];

   pixel_stream_reader #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof)
`ifdef PIX_STREAM_CKSUM_EN
     ,.cksum(cksum)
`endif
   );

   pixel_stream_reader #(.WIDTH(1), .HEIGHT(1), .ADDR_W(AW)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
      .pix_valid(pix_valid1), .pix_ready(pix_ready1),
      .pix_r(pix_r1), .pix_g(pix_g1), .pix_b(pix_b1),
      .pix_sol(pix_sol1), .pix_eol(pix_eol1), .pix_eof(pix_eof1)
`ifdef PIX_STREAM_CKSUM_EN
     ,.cksum(cksum1)
`endif
   );

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (done) begin
            cyc = c;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; start1 = 1'b0; pix_ready = 1'b0; pix_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tot_cnt++;
      if ({busy, done, mem_rd, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_sol, pix_eol, pix_eof} !== '0)
         $display("FAIL reset_outputs: got %h exp 0",
                  {busy, done, mem_rd, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_sol, pix_eol, pix_eof});
      else pass_cnt++;
      tot_cnt++;
      if ({busy1, done1, mem_rd1, mem_addr1, pix_valid1, pix_r1} !== '0)
         $display("FAIL reset_outputs_1x1: got %h exp 0", {busy1, done1, mem_rd1, mem_addr1, pix_valid1, pix_r1});
      else pass_cnt++;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tot_cnt++;
      if ({busy, mem_rd, pix_valid, done} !== 4'b0000)
         $display("FAIL idle_after_reset: got %b exp 0000", {busy, mem_rd, pix_valid, done});
      else pass_cnt++;
   endtask

   task automatic test_basic();
      int p, nd, dcyc;
      logic busy_after;
      logic [2:0] ef;
      p = 0; nd = 0; dcyc = -10; busy_after = 1'b1;
      pix_ready = 1'b1;
      do_start();
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (c == dcyc + 1) busy_after = busy;
         if (pix_valid) begin
            if (p == 0) begin
               tot_cnt++;
               if (c != 4) $display("FAIL basic_first_latency: got %0d exp 4", c);
               else pass_cnt++;
            end
            tot_cnt++;
            if ({pix_r, pix_g, pix_b} !== {8'(3*p), 8'(3*p+1), 8'(3*p+2)})
               $display("FAIL basic_data_%0d: got %h exp %h", p, {pix_r, pix_g, pix_b},
                        {8'(3*p), 8'(3*p+1), 8'(3*p+2)});
            else pass_cnt++;
            ef = {(p % 4 == 0), (p % 4 == 3), (p == 7)};
            tot_cnt++;
            if ({pix_sol, pix_eol, pix_eof} !== ef)
               $display("FAIL basic_flags_%0d: got %b exp %b", p, {pix_sol, pix_eol, pix_eof}, ef);
            else pass_cnt++;
            p++;
         end
         if (done) begin
            nd++;
            dcyc = c;
         end
      end
      tot_cnt++;
      if (p != 8) $display("FAIL basic_pixel_count: got %0d exp 8", p); else pass_cnt++;
      tot_cnt++;
      if (nd != 1) $display("FAIL basic_done_count: got %0d exp 1", nd); else pass_cnt++;
      tot_cnt++;
      if (dcyc != 40) $display("FAIL basic_start_to_done: got %0d exp 40", dcyc); else pass_cnt++;
      tot_cnt++;
      if (busy_after !== 1'b0) $display("FAIL basic_busy_after_done: got %b exp 0", busy_after);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int p, c, dc;
      p = 0; c = 0;
      pix_ready = 1'b1;
      do_start();
      while (p < 2 && c < 50) begin
         @(posedge clk); #1;
         c++;
         if (pix_valid) p++;
      end
      pix_ready = 1'b0;
      tot_cnt++;
      if (p != 2) $display("FAIL bp_reach_pixel2: got %0d exp 2", p); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         tot_cnt++;
         if ({pix_valid, pix_r, pix_g, pix_b, mem_rd} !== {1'b1, 8'h03, 8'h04, 8'h05, 1'b0})
            $display("FAIL bp_hold_%0d: got %h exp %h", i, {pix_valid, pix_r, pix_g, pix_b, mem_rd},
                     {1'b1, 8'h03, 8'h04, 8'h05, 1'b0});
         else pass_cnt++;
      end
      pix_ready = 1'b1;
      @(posedge clk); #1;
      tot_cnt++;
      if ({mem_rd, mem_addr} !== {1'b1, 20'd6})
         $display("FAIL bp_next_addr: got rd=%b addr=%0d exp rd=1 addr=6", mem_rd, mem_addr);
      else pass_cnt++;
      wait_done(dc);
      tot_cnt++;
      if (dc < 0) $display("FAIL bp_done: got timeout exp done"); else pass_cnt++;
   endtask

   task automatic test_start_busy();
      int p, nd, dcyc, bad;
      logic busy_after, rd_after;
      p = 0; nd = 0; dcyc = -10; bad = 0; busy_after = 1'b1; rd_after = 1'b1;
      pix_ready = 1'b1;
      do_start();
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == dcyc + 1) begin
            busy_after = busy;
            rd_after   = mem_rd;
         end
         if (pix_valid) begin
            if (pix_r !== 8'(3*p)) bad++;
            p++;
            if (p == 3) start = 1'b1;
         end
         if (done) begin
            nd++;
            dcyc = c;
            start = 1'b1;
         end
      end
      start = 1'b0;
      tot_cnt++;
      if (p != 8) $display("FAIL sb_pixel_count: got %0d exp 8", p); else pass_cnt++;
      tot_cnt++;
      if (nd != 1) $display("FAIL sb_done_count: got %0d exp 1", nd); else pass_cnt++;
      tot_cnt++;
      if (bad != 0) $display("FAIL sb_data: got %0d bad pixels exp 0", bad); else pass_cnt++;
      tot_cnt++;
      if ({busy_after, rd_after} !== 2'b00)
         $display("FAIL sb_start_on_done_ignored: got busy=%b rd=%b exp 0 0", busy_after, rd_after);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int nd, c, dc;
      nd = 0;
      pix_ready = 1'b1;
      do_start();
      repeat (21) @(posedge clk);
      #1;
      tot_cnt++;
      if ({mem_rd, mem_addr} !== {1'b1, 20'd13})
         $display("FAIL mr_in_rd_g: got rd=%b addr=%0d exp rd=1 addr=13", mem_rd, mem_addr);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      tot_cnt++;
      if ({busy, done, mem_rd, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_sol, pix_eol, pix_eof} !== '0)
         $display("FAIL mr_async_clear: got %h exp 0",
                  {busy, done, mem_rd, mem_addr, pix_valid, pix_r, pix_g, pix_b, pix_sol, pix_eol, pix_eof});
      else pass_cnt++;
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done || busy) nd++;
      end
      tot_cnt++;
      if (nd != 0) $display("FAIL mr_no_done: got %0d active cycles exp 0", nd); else pass_cnt++;
      do_start();
      tot_cnt++;
      if ({mem_rd, mem_addr} !== {1'b1, 20'd0})
         $display("FAIL mr_restart_addr: got rd=%b addr=%0d exp rd=1 addr=0", mem_rd, mem_addr);
      else pass_cnt++;
      c = 0;
      while (!pix_valid && c < 10) begin
         @(posedge clk); #1;
         c++;
      end
      tot_cnt++;
      if ({pix_valid, pix_r, pix_g, pix_b, pix_sol} !== {1'b1, 8'h00, 8'h01, 8'h02, 1'b1})
         $display("FAIL mr_first_pixel: got %h exp %h", {pix_valid, pix_r, pix_g, pix_b, pix_sol},
                  {1'b1, 8'h00, 8'h01, 8'h02, 1'b1});
      else pass_cnt++;
      wait_done(dc);
      tot_cnt++;
      if (dc < 0) $display("FAIL mr_done: got timeout exp done"); else pass_cnt++;
   endtask

`ifdef PIX_STREAM_CKSUM_EN
   task automatic test_cksum();
      int dc;
      pix_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         do_start();
         tot_cnt++;
         if (cksum !== 16'h0000) $display("FAIL ck_clear_%0d: got %h exp 0000", f, cksum); else pass_cnt++;
         wait_done(dc);
         tot_cnt++;
         if (dc < 0 || cksum !== 16'h0114)
            $display("FAIL ck_sum_%0d: got %h (done cyc %0d) exp 0114", f, cksum, dc);
         else pass_cnt++;
      end
   endtask
`endif

   task automatic test_degenerate();
      int p, nd, dcyc;
      logic [AW-1:0] maxa;
      p = 0; nd = 0; dcyc = -1; maxa = '0;
      pix_ready1 = 1'b1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (mem_addr1 > maxa) maxa = mem_addr1;
         if (pix_valid1) begin
            tot_cnt++;
            if ({pix_r1, pix_g1, pix_b1, pix_sol1, pix_eol1, pix_eof1} !== {8'h00, 8'h01, 8'h02, 3'b111})
               $display("FAIL deg_pixel: got %h exp %h", {pix_r1, pix_g1, pix_b1, pix_sol1, pix_eol1, pix_eof1},
                        {8'h00, 8'h01, 8'h02, 3'b111});
            else pass_cnt++;
            p++;
         end
         if (done1) begin
            nd++;
            dcyc = c;
         end
      end
      tot_cnt++;
      if (p != 1 || nd != 1) $display("FAIL deg_counts: got pix=%0d done=%0d exp 1 1", p, nd);
      else pass_cnt++;
      tot_cnt++;
      if (dcyc != 5) $display("FAIL deg_done_cycle: got %0d exp 5", dcyc); else pass_cnt++;
      tot_cnt++;
      if (maxa !== 20'd2) $display("FAIL deg_max_addr: got %0d exp 2", maxa); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_start_busy();
      test_mid_reset();
`ifdef PIX_STREAM_CKSUM_EN
      test_cksum();
`endif
      test_degenerate();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
